// File: rtl/jogo_adivinha_4bits.sv
// Number-guessing round controller: draws a secret from a free-running LFSR, feeds guess/secret to an
// external comparator and turns its flags into hints, attempt count and win/loss. Macro JOGO_DICA_EN enables hint LEDs.
module jogo_adivinha_4bits #(
  parameter int         MAX_TENTATIVAS = 5,
  parameter logic [3:0] LFSR_SEED      = 4'b1001
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       submit,
  input  logic [3:0] guess,
  output logic       a0,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic       b0,
  output logic       b1,
  output logic       b2,
  output logic       b3,
  input  logic       eq,
  input  logic       gt,
  input  logic       lt,
  output logic       led_maior,
  output logic       led_menor,
  output logic       led_acerto,
  output logic       led_derrota,
  output logic [2:0] tentativas
);

  typedef enum logic [2:0] {IDLE, ESPERA, AVALIA, VITORIA, DERROTA} state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [3:0] SEED  = (LFSR_SEED == 4'd0) ? 4'b0001 : LFSR_SEED;
  localparam logic [2:0] MAX_T = 3'(MAX_TENTATIVAS);

  state_t     state_reg, state_next;
  logic [3:0] a_reg, a_next;
  logic [3:0] b_reg, b_next;
  logic [3:0] lfsr_reg, lfsr_next;
  logic       start_prev_reg, start_prev_next;
  logic       submit_prev_reg, submit_prev_next;
  logic       maior_reg, maior_next;
  logic       menor_reg, menor_next;
  logic       acerto_reg, acerto_next;
  logic       derrota_reg, derrota_next;
  logic [2:0] tent_reg, tent_next;
  logic       start_rise;
  logic       submit_rise;

  assign start_rise  = start & ~start_prev_reg;
  assign submit_rise = submit & ~submit_prev_reg;

`ifndef JOGO_DICA_EN
  logic unused_hint;
  assign unused_hint = gt ^ lt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      a_reg           <= 4'd0;
      b_reg           <= 4'd0;
      lfsr_reg        <= SEED;
      start_prev_reg  <= 1'b0;
      submit_prev_reg <= 1'b0;
      maior_reg       <= 1'b0;
      menor_reg       <= 1'b0;
      acerto_reg      <= 1'b0;
      derrota_reg     <= 1'b0;
      tent_reg        <= 3'd0;
    end else begin
      state_reg       <= state_next;
      a_reg           <= a_next;
      b_reg           <= b_next;
      lfsr_reg        <= lfsr_next;
      start_prev_reg  <= start_prev_next;
      submit_prev_reg <= submit_prev_next;
      maior_reg       <= maior_next;
      menor_reg       <= menor_next;
      acerto_reg      <= acerto_next;
      derrota_reg     <= derrota_next;
      tent_reg        <= tent_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    a_next           = a_reg;
    b_next           = b_reg;
    lfsr_next        = {lfsr_reg[2:0], lfsr_reg[3] ^ lfsr_reg[2]};
    start_prev_next  = start;
    submit_prev_next = submit;
    maior_next       = maior_reg;
    menor_next       = menor_reg;
    acerto_next      = acerto_reg;
    derrota_next     = derrota_reg;
    tent_next        = tent_reg;

    // A new round overrides everything, including a pending evaluation.
    if (start_rise) begin
      b_next       = lfsr_reg;
      a_next       = 4'd0;
      tent_next    = 3'd0;
      maior_next   = 1'b0;
      menor_next   = 1'b0;
      acerto_next  = 1'b0;
      derrota_next = 1'b0;
      state_next   = ESPERA;
    end else begin
      case (state_reg)
        ESPERA: begin
          if (submit_rise) begin
            a_next = guess;
            if (tent_reg < MAX_T) tent_next = tent_reg + 3'd1;
            state_next = AVALIA;
          end
        end
        AVALIA: begin
          if (eq) begin
            acerto_next = 1'b1;
            maior_next  = 1'b0;
            menor_next  = 1'b0;
            state_next  = VITORIA;
          end else if (tent_reg == MAX_T) begin
            derrota_next = 1'b1;
            maior_next   = 1'b0;
            menor_next   = 1'b0;
            state_next   = DERROTA;
          end else begin
`ifdef JOGO_DICA_EN
            maior_next = gt;
            menor_next = lt & ~gt;
`else
            maior_next = 1'b0;
            menor_next = 1'b0;
`endif
            state_next = ESPERA;
          end
        end
        default: ;
      endcase
    end
  end

  assign {a3, a2, a1, a0} = a_reg;
  assign {b3, b2, b1, b0} = b_reg;
  assign led_maior   = maior_reg;
  assign led_menor   = menor_reg;
  assign led_acerto  = acerto_reg;
  assign led_derrota = derrota_reg;
  assign tentativas  = tent_reg;

endmodule

// File: tb/tb_jogo_adivinha_4bits.sv
// Scoreboard bench for jogo_adivinha_4bits: a game-level model predicts the outputs of each
// transaction, a monitor compares them on the falling edge at the predicted cycle.
module tb_jogo_adivinha_4bits;
  localparam int         MAX  = 5;
  localparam logic [3:0] SEED = 4'b1001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic submit = 1'b0;
  logic [3:0] guess = 4'd0;
  logic a0, a1, a2, a3, b0, b1, b2, b3;
  logic eq, gt, lt;
  logic led_maior, led_menor, led_acerto, led_derrota;
  logic [2:0] tentativas;
  logic [3:0] a_bus, b_bus;

  always #5 clk = ~clk;

  jogo_adivinha_4bits #(.MAX_TENTATIVAS(MAX), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .submit(submit), .guess(guess),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .eq(eq), .gt(gt), .lt(lt),
    .led_maior(led_maior), .led_menor(led_menor), .led_acerto(led_acerto),
    .led_derrota(led_derrota), .tentativas(tentativas)
  );

  // Behavioural stand-in for comparador_4bits
  assign a_bus = {a3, a2, a1, a0};
  assign b_bus = {b3, b2, b1, b0};
  assign eq = (a_bus == b_bus);
  assign gt = (a_bus > b_bus);
  assign lt = (a_bus < b_bus);

  typedef struct {
    int         cyc;
    string      tag;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] t;
    logic [3:0] leds;  // {maior, menor, acerto, derrota}
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Game-level model
  bit         m_active, m_over;
  logic [3:0] m_secret, m_a, m_b, m_leds;
  int         m_t;
  int         rel_cyc;

  function automatic logic [3:0] lfsr_at(input int k);
    logic [3:0] v;
    int n;
    v = SEED;
    n = (k - rel_cyc) % 15;
    for (int i = 0; i < n; i++) v = {v[2:0], v[3] ^ v[2]};
    return v;
  endfunction

  task automatic model_reset();
    m_active = 0; m_over = 0; m_a = 0; m_b = 0; m_t = 0; m_leds = 0; m_secret = 0;
  endtask

  task automatic model_start(input int k);
    m_secret = lfsr_at(k);
    m_active = 1; m_over = 0; m_a = 0; m_b = m_secret; m_t = 0; m_leds = 0;
  endtask

  task automatic model_submit(input logic [3:0] g);
    if (m_active && !m_over) begin
      m_a = g;
      m_t = m_t + 1;
      if (g == m_secret) begin
        m_leds = 4'b0010; m_over = 1;
      end else if (m_t == MAX) begin
        m_leds = 4'b0001; m_over = 1;
      end else begin
`ifdef JOGO_DICA_EN
        m_leds = {g > m_secret, g < m_secret, 2'b00};
`else
        m_leds = 4'b0000;
`endif
      end
    end
  endtask

  task automatic push(input int at, input string tag);
    exp_t e;
    e.cyc = at; e.tag = tag; e.a = m_a; e.b = m_b; e.t = 3'(m_t); e.leds = m_leds;
    sb.push_back(e);
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] leds;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      leds = {led_maior, led_menor, led_acerto, led_derrota};
      checks++;
      if (e.cyc < cyc) begin
        errors++;
        $display("FAIL %s stale: expected at cycle %0d, seen at %0d", e.tag, e.cyc, cyc);
      end else begin
        checks += 3;
        if (a_bus !== e.a) begin errors++; $display("FAIL %s a got %0d want %0d", e.tag, a_bus, e.a); end
        if (b_bus !== e.b) begin errors++; $display("FAIL %s b got %0d want %0d", e.tag, b_bus, e.b); end
        if (tentativas !== e.t) begin errors++; $display("FAIL %s tentativas got %0d want %0d", e.tag, tentativas, e.t); end
        if (leds !== e.leds) begin errors++; $display("FAIL %s leds got %b want %b", e.tag, leds, e.leds); end
      end
      $display("cyc %0d %-10s a=%0d b=%0d t=%0d leds=%b", cyc, e.tag, a_bus, b_bus, tentativas, leds);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_start(input string tag);
    start = 1'b1;
    model_start(cyc);
    push(cyc + 2, tag);
    tick(); start = 1'b0; tick(); tick();
  endtask

  task automatic do_submit(input logic [3:0] g, input string tag);
    guess = g; submit = 1'b1;
    model_submit(g);
    push(cyc + 2, tag);
    tick(); submit = 1'b0; tick(); tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    push(cyc, "reset");
    tick();
    rst_n = 1'b1;
    rel_cyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;
    model_reset();
    rel_cyc = 0;
    tick();
    push(cyc, "reset0");
    tick();
    rst_n = 1'b1;
    rel_cyc = cyc;

    // First edge after reset: secret must be the seed
    do_start("start9");
    do_submit(4'd4, "low");
    do_submit(4'd12, "high");
    do_submit(4'd9, "win");
    do_submit(4'd3, "after_win");
    do_submit(4'd9, "after_win");

    // Loss: five wrong guesses, sixth ignored
    do_start("start_loss");
    for (int i = 0; i < 6; i++) do_submit(4'((int'(m_secret) + i + 1) % 16), "loss");

    // Held submit counts once
    do_start("start_hold");
    g = m_secret ^ 4'b0100;
    guess = g; submit = 1'b1;
    model_submit(g);
    push(cyc + 2, "hold");
    repeat (10) tick();
    push(cyc, "hold_end");
    submit = 1'b0; tick(); tick();

    // start and submit rising together: start wins
    start = 1'b1; submit = 1'b1; guess = 4'd7;
    model_start(cyc);
    push(cyc + 2, "start+sub");
    tick(); start = 1'b0; tick(); submit = 1'b0; tick(); tick();

    // start during evaluation discards it
    guess = m_secret; submit = 1'b1;
    tick(); submit = 1'b0; start = 1'b1;
    model_start(cyc);
    push(cyc + 2, "start_aval");
    tick(); start = 1'b0; tick(); tick();

    // Asynchronous reset mid-round, then IDLE ignores submit
    do_submit(m_secret ^ 4'b0001, "pre_reset");
    do_reset();
    do_submit(4'd5, "idle_sub");

    // Randomized rounds
    for (int r = 0; r < 8; r++) begin
      repeat ($urandom_range(0, 7)) tick();
      do_start("rnd_start");
      for (int s = 0; s < 7; s++) begin
        g = ($urandom_range(0, 3) == 0) ? m_secret : 4'($urandom_range(0, 15));
        do_submit(g, "rnd_sub");
      end
    end

    tick(); tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
